div_freq_meter: RTL and testbench
=================================

Name: div_freq_meter

Overview:
- Downstream checker/consumer of the clock divider output.
- Samples the divided signal in the source clock domain and measures one full period and its high time, in source-clock cycles.
- Reports the result through a valid/ready handshake, with a duty-cycle check and a timeout flag.
- Used for in-system self-test of the divider and as a bench monitor.

Parameters:
- CNT_W, 16, width of period/high_time counters and outputs.
- TIMEOUT, 1024, max active cycles per measurement; legal range 4 <= TIMEOUT < 2^CNT_W, so counters never saturate.

Ports:
- clk  input  1  source clock; the divider runs on the same clock.
- rst_n  input  1  reset, synchronous, active-low.
- div_in  input  1  divided signal under measurement.
- start  input  1  request one measurement; accepted only in IDLE.
- busy  output  1  high in ARM/HIGH/LOW.
- meas_valid  output  1  result available (DONE state).
- meas_ready  input  1  consumer accepts result.
- period  output  CNT_W  cycles from rising edge to next rising edge.
- high_time  output  CNT_W  cycles div_in sampled high within that period.
- duty_ok  output  1  1 when |2*high_time - period| <= 1.
- timeout  output  1  measurement aborted by watchdog.

Behaviour:
- Clock, reset and registers:
  - One clock; reset is synchronous and active-low on rst_n.
  - All registers use posedge clk.
  - rst_n=0 at a clock edge forces IDLE and clears d_q, counters, period, high_time, duty_ok, timeout, busy and meas_valid to 0.
  - Reset mid-measurement aborts with no result.
- Edge detection:
  - d_q <= div_in every cycle, regardless of state.
  - rise = div_in & ~d_q.
  - div_in is synchronous to clk; there is no synchronizer.
- State machine: IDLE, ARM, HIGH, LOW, DONE.
- IDLE:
  - start=1 -> ARM; clear the wd counter.
  - A rise in the start cycle itself is not counted.
- ARM:
  - On rise -> HIGH with cnt_hi=1, cnt_per=1.
  - div_in already high on entry does not count; ARM waits for a fresh rise.
- HIGH:
  - div_in=1: cnt_hi+=1, cnt_per+=1.
  - div_in=0: cnt_per+=1, go to LOW.
- LOW:
  - div_in=1 (rise): latch period=cnt_per and high_time=cnt_hi, compute duty_ok, timeout=0, go to DONE.
  - Otherwise cnt_per+=1.
- Watchdog:
  - wd increments every cycle in ARM/HIGH/LOW.
  - In the cycle wd==TIMEOUT-1 with no completion: go to DONE with period=0, high_time=0, duty_ok=0, timeout=1.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE:
  - meas_valid=1; period, high_time, duty_ok and timeout are held stable.
  - meas_valid & meas_ready -> IDLE, meas_valid=0 next cycle.
  - start is ignored in DONE and in every state other than IDLE; no queuing.
- Latency:
  - meas_valid rises in the cycle after the second rising edge is sampled.
  - If start is accepted at cycle t: a timeout gives meas_valid at t+TIMEOUT+1.
  - A new start is accepted no earlier than the cycle after the handshake.
- Output hold: results keep their last values in IDLE until the next DONE overwrites them. timeout is cleared on completion.
- Expected divider readings:
  - Even divide-by-N: period=N, high_time=N/2.
  - Odd divide-by-N sampled on posedge: period=N, high_time=(N-1)/2 or (N+1)/2. Both give duty_ok=1.

Test Plan:
- Divide-by-4 waveform (2 high/2 low) on div_in, start pulse -> period=4, high_time=2, duty_ok=1, timeout=0; meas_valid 1 cycle after the 2nd rise.
- Divide-by-5 waveform (3 high/2 low), then (2 high/3 low) -> period=5, high_time=3 then 2, duty_ok=1 both times.
- div_in held 0 with TIMEOUT=16, start at cycle t -> meas_valid at t+17, timeout=1, period=0, high_time=0, duty_ok=0.
- Skewed waveform (1 high/5 low) with meas_ready held 0 for 10 cycles, and start pulsed during DONE:
  - period=6, high_time=1, duty_ok=0.
  - Outputs stable for all 10 cycles; start ignored.
  - IDLE the cycle after meas_ready=1.
- start asserted while div_in already high mid-pulse -> the partial pulse is ignored; the measurement begins at the next rise with correct period/high_time.
- rst_n=0 for one cycle during HIGH -> busy=0, meas_valid=0 and all outputs 0 next cycle. A subsequent start measures correctly.

Source files
------------

// File: rtl/div_freq_meter.sv
// Measures one period and the high time of div_in in clk cycles, with a duty-cycle check
// and a watchdog. The result is held behind a valid/ready handshake until it is accepted.
module div_freq_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_ok,
  output logic             timeout
);

  typedef enum logic [2:0] {StIdle, StArm, StHigh, StLow, StDone} state_e;

  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             duty_ok_q, duty_ok_d;
  logic             timeout_q, timeout_d;

  logic             rise;
  logic             active;
  logic             complete;
  logic             duty_calc;
  logic [CNT_W+1:0] twice_hi;
  logic [CNT_W+1:0] per_ext;
  logic [CNT_W+1:0] duty_diff;

  assign rise   = div_in & ~d_q;
  assign active = (state_q == StArm) || (state_q == StHigh) || (state_q == StLow);

  // |2*high - period| <= 1, evaluated on the counters at the closing rise
  always_comb begin
    twice_hi  = {1'b0, cnt_hi_q, 1'b0};
    per_ext   = {2'b00, cnt_per_q};
    duty_diff = (twice_hi >= per_ext) ? (twice_hi - per_ext) : (per_ext - twice_hi);
    duty_calc = (duty_diff <= (CNT_W + 2)'(1));
  end

  always_comb begin
    state_d     = state_q;
    d_d         = div_in;
    cnt_hi_d    = cnt_hi_q;
    cnt_per_d   = cnt_per_q;
    wd_d        = active ? (wd_q + CntOne) : wd_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_ok_d   = duty_ok_q;
    timeout_d   = timeout_q;
    complete    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StArm;
          wd_d    = '0;
        end
      end
      StArm: begin
        if (rise) begin
          state_d   = StHigh;
          cnt_hi_d  = CntOne;
          cnt_per_d = CntOne;
        end
      end
      StHigh: begin
        cnt_per_d = cnt_per_q + CntOne;
        if (div_in) begin
          cnt_hi_d = cnt_hi_q + CntOne;
        end else begin
          state_d = StLow;
        end
      end
      StLow: begin
        if (div_in) begin
          state_d     = StDone;
          period_d    = cnt_per_q;
          high_time_d = cnt_hi_q;
          duty_ok_d   = duty_calc;
          timeout_d   = 1'b0;
          complete    = 1'b1;
        end else begin
          cnt_per_d = cnt_per_q + CntOne;
        end
      end
      StDone: begin
        if (meas_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog abort; a completion in the same cycle takes priority
    if (active && !complete && (wd_q == WdLast)) begin
      state_d     = StDone;
      period_d    = '0;
      high_time_d = '0;
      duty_ok_d   = 1'b0;
      timeout_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      d_q         <= 1'b0;
      cnt_hi_q    <= '0;
      cnt_per_q   <= '0;
      wd_q        <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_ok_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      cnt_hi_q    <= cnt_hi_d;
      cnt_per_q   <= cnt_per_d;
      wd_q        <= wd_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_ok_q   <= duty_ok_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy       = active;
  assign meas_valid = (state_q == StDone);
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign duty_ok    = duty_ok_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_div_freq_meter.sv
// Bench for div_freq_meter: directed divider waveforms plus random ones, each result checked
// against a reference computed from the sampled div_in history.
module tb_div_freq_meter;

  localparam int CntW = 16;
  localparam int Tmo  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            div_in = 1'b0;
  logic            start = 1'b0;
  logic            meas_ready = 1'b0;
  logic            busy;
  logic            meas_valid;
  logic [CntW-1:0] period;
  logic [CntW-1:0] high_time;
  logic            duty_ok;
  logic            timeout;

  int tests = 0;
  int fails = 0;
  bit hist[$];  // div_in as seen by the DUT at each clock edge (0 at reset edges)

  div_freq_meter #(
    .CNT_W   (CntW),
    .TIMEOUT (Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_in     (div_in),
    .start      (start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period     (period),
    .high_time  (high_time),
    .duty_ok    (duty_ok),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    hist.push_back(rst_n ? div_in : 1'b0);
    @(posedge clk);
    #1;
  endtask

  function automatic bit wave(input int hi, input int lo, input int phase, input int i);
    if (hi == 0) return 1'b0;
    return ((i + phase) % (hi + lo)) < hi;
  endfunction

  function automatic bit rise_at(input int c);
    return hist[c] && !hist[c-1];
  endfunction

  // First rise after the start edge opens the period, the next rise closes it; both must
  // land within TIMEOUT edges of the start edge or the watchdog result is expected.
  function automatic void model(input int s, output int per, output int hi, output int to,
                                output int duty, output int done);
    int r1 = -1;
    int r2 = -1;
    for (int c = s + 1; c <= s + Tmo && c < hist.size(); c++)
      if (rise_at(c)) begin r1 = c; break; end
    if (r1 >= 0)
      for (int c = r1 + 1; c <= s + Tmo && c < hist.size(); c++)
        if (rise_at(c)) begin r2 = c; break; end
    if (r2 >= 0) begin
      per = r2 - r1;
      hi  = 0;
      for (int c = r1; c < r2; c++) hi += int'(hist[c]);
      to   = 0;
      duty = ((2 * hi - per) >= -1 && (2 * hi - per) <= 1) ? 1 : 0;
      done = r2;
    end else begin
      per = 0; hi = 0; to = 1; duty = 0;
      done = s + Tmo;
    end
  endfunction

  task automatic measure(input int hi, input int lo, input int phase, input int hold,
                         input bit poke);
    int s, i, done_obs, e_per, e_hi, e_to, e_duty, e_done;
    chk("idle_busy", busy, 0);
    chk("idle_valid", meas_valid, 0);
    i = 0;
    div_in = wave(hi, lo, phase, i);
    start = 1'b1;
    tick();
    s = hist.size() - 1;
    start = 1'b0;
    i++;
    chk("busy_after_start", busy, 1);
    done_obs = -1;
    for (int n = 0; n < Tmo + 8; n++) begin
      div_in = wave(hi, lo, phase, i);
      i++;
      tick();
      if (meas_valid) begin
        done_obs = hist.size() - 1;
        break;
      end
    end
    model(s, e_per, e_hi, e_to, e_duty, e_done);
    chk("done_edge", done_obs, e_done);
    chk("period", period, e_per);
    chk("high_time", high_time, e_hi);
    chk("duty_ok", duty_ok, e_duty);
    chk("timeout", timeout, e_to);
    chk("busy_in_done", busy, 0);
    meas_ready = 1'b0;
    for (int n = 0; n < hold; n++) begin
      div_in = wave(hi, lo, phase, i);
      i++;
      start = poke ? n[0] : 1'b0;
      tick();
      chk("hold_valid", meas_valid, 1);
      chk("hold_period", period, e_per);
      chk("hold_high", high_time, e_hi);
      chk("hold_duty", duty_ok, e_duty);
      chk("hold_timeout", timeout, e_to);
    end
    meas_ready = 1'b1;
    start = poke;
    div_in = wave(hi, lo, phase, i);
    tick();
    meas_ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", meas_valid, 0);
    chk("hs_busy", busy, 0);
    chk("idle_hold_period", period, e_per);
    chk("idle_hold_high", high_time, e_hi);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_duty", duty_ok, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    div_in = 1'b0;
    tick();

    measure(2, 2, 0, 0, 1'b0);
    chk("d4_period", period, 4);
    chk("d4_high", high_time, 2);
    chk("d4_duty", duty_ok, 1);
    chk("d4_timeout", timeout, 0);

    measure(3, 2, 0, 1, 1'b0);
    chk("d5a_period", period, 5);
    chk("d5a_high", high_time, 3);
    chk("d5a_duty", duty_ok, 1);

    measure(2, 3, 0, 1, 1'b0);
    chk("d5b_period", period, 5);
    chk("d5b_high", high_time, 2);
    chk("d5b_duty", duty_ok, 1);

    measure(0, 1, 0, 2, 1'b0);
    chk("to_timeout", timeout, 1);
    chk("to_period", period, 0);
    chk("to_high", high_time, 0);
    chk("to_duty", duty_ok, 0);

    measure(1, 5, 0, 10, 1'b1);
    chk("skew_period", period, 6);
    chk("skew_high", high_time, 1);
    chk("skew_duty", duty_ok, 0);
    chk("skew_timeout", timeout, 0);

    measure(4, 4, 1, 0, 1'b0);
    chk("mid_period", period, 8);
    chk("mid_high", high_time, 4);

    // Reset while in HIGH
    div_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    div_in = 1'b1;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", meas_valid, 0);
    chk("mrst_period", period, 0);
    chk("mrst_high", high_time, 0);
    chk("mrst_duty", duty_ok, 0);
    chk("mrst_timeout", timeout, 0);
    div_in = 1'b0;
    tick();
    measure(3, 3, 0, 1, 1'b0);
    chk("post_rst_period", period, 6);
    chk("post_rst_high", high_time, 3);

    for (int n = 0; n < 12; n++) begin
      int hi, lo, ph, hd;
      hi = int'($urandom_range(0, 5));
      lo = int'($urandom_range(1, 6));
      ph = int'($urandom_range(0, 11));
      hd = int'($urandom_range(0, 3));
      div_in = 1'($urandom_range(0, 1));
      tick();
      measure(hi, lo, ph, hd, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
